// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam logic [63:0] PC_RESET_VECTOR = 64'h0;
    localparam logic [63:0] PC_EXC_VECTOR   = 64'h100;

    // Low-bit mask that must be zero for an instruction-aligned address.
    function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
        return 64'(instr_bytes) - 64'd1;
    endfunction

endpackage

// File: rtl/pc_if.sv
// Branch/execute <-> PC unit <-> fetch signal bundle.
interface pc_if #(
    parameter int unsigned WIDTH = 64
);
    logic             w;
    logic             fetch_ready;
    logic             br_taken;
    logic             br_reg;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] reg_target;
    logic             exc;
    logic             halt;
    logic             ras_push;
    logic             ras_pop;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic             misalign;
    logic [1:0]       state;

    modport master (
        output w, fetch_ready, br_taken, br_reg, br_offset, reg_target,
               exc, halt, ras_push, ras_pop,
        input  pc, pc_valid, misalign, state
    );

    modport slave (
        input  w, fetch_ready, br_taken, br_reg, br_offset, reg_target,
               exc, halt, ras_push, ras_pop,
        output pc, pc_valid, misalign, state
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_inc;
    logic [AW:0]      count;
    logic             do_pop;

    assign empty   = (count == '0);
    assign top     = mem[ptr];
    assign do_pop  = pop && !empty;
    assign ptr_inc = ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_pop && push) begin
            // Pop-then-push collapses to replacing the top entry.
            mem[ptr] <= push_data;
        end else if (do_pop) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end else if (push) begin
            ptr          <= ptr_inc;
            mem[ptr_inc] <= push_data;
            if (count != FULL) count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC selection, fetch handshake and boot/run/halt FSM.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 64,
    parameter int unsigned      INSTR_BYTES  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR),
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input logic clk,
    input logic rst,
    pc_if.slave bus
);
    localparam logic [WIDTH-1:0] INC        = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(align_mask(INSTR_BYTES));

    pc_state_t        state_q, state_n;
    logic [WIDTH-1:0] pc_q, pc_n;
    logic             mis_q, mis_n;
    logic             adv;
    logic [WIDTH-1:0] rel_target;
    logic [WIDTH-1:0] target;

    assign adv        = bus.w & bus.fetch_ready;
    assign rel_target = pc_q + (bus.br_offset * INC);

`ifdef PC_RAS_EN
    logic             ras_empty;
    logic [WIDTH-1:0] ras_top;
    logic             ras_hit;
    logic             run_adv;

    assign ras_hit = bus.br_reg & bus.ras_pop & ~ras_empty;
    assign target  = bus.br_reg ? (ras_hit ? ras_top : bus.reg_target) : rel_target;
    // Stack only moves on the same path that lets the PC advance.
    assign run_adv = (state_q == RUN) & ~bus.exc & ~bus.halt & adv;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (run_adv & bus.ras_push),
        .pop       (run_adv & bus.br_taken & ras_hit),
        .push_data (pc_q + INC),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    assign target = bus.br_reg ? bus.reg_target : rel_target;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            mis_q   <= mis_n;
        end
    end

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        mis_n   = mis_q;
        case (state_q)
            BOOT: state_n = RUN;
            RUN: begin
                if (bus.exc) begin
                    pc_n = EXC_VECTOR;
                end else if (bus.halt) begin
                    state_n = HALTED;
                end else if (adv && bus.br_taken) begin
                    pc_n = target;
                    if ((target & ALIGN_MASK) != '0) begin
                        mis_n   = 1'b1;
                        state_n = HALTED;
                    end
                end else if (adv) begin
                    pc_n = pc_q + INC;
                end
            end
            default: ;
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.pc_valid = (state_q == RUN);
    assign bus.misalign = mis_q;
    assign bus.state    = state_q;

endmodule
